// File: rtl/case_4_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : case_4_acc_pkg
//  Description : Shared types, default sizes and helpers for the
//                case_4 product accumulator.
//  Revision    : 1.0  initial release
// ============================================================================
package case_4_acc_pkg;

   localparam int DEF_IN_WIDTH  = 8;
   localparam int DEF_ACC_WIDTH = 10;
   localparam int DEF_OUT_WIDTH = 8;
   localparam int DEF_COUNT     = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Sign-extend the low w bits of d to 32 bits; callers truncate to their width.
   function automatic logic [31:0] sext_in(input logic [31:0] d, input int unsigned w);
      logic [31:0] hi;
      hi = 32'hFFFF_FFFF << w;
      return d[5'(w - 1)] ? (d | hi) : (d & ~hi);
   endfunction

endpackage
`default_nettype wire

// File: rtl/case_4_prod_accum_if.sv
`default_nettype none
// ============================================================================
//  Module      : case_4_prod_accum_if
//  Description : Product input stream and group result output stream,
//                both valid/ready. slave = accumulator side,
//                master = producer/consumer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface case_4_prod_accum_if #(
   parameter int IN_WIDTH  = 8,
   parameter int OUT_WIDTH = 8
);
   logic [IN_WIDTH-1:0]  in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_sat;

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_sat
   );

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_sat
   );
endinterface
`default_nettype wire

// File: rtl/case_4_acc_sat.sv
`default_nettype none
// ============================================================================
//  Module      : case_4_acc_sat
//  Description : Reduces the ACC_WIDTH group sum to an OUT_WIDTH result.
//                Macro CASE_4_ACC_SATURATE_EN selects clamping with a
//                saturation flag; otherwise the sum is truncated and the
//                flag is 0.
//  Revision    : 1.0  initial release
// ============================================================================
module case_4_acc_sat #(
   parameter int ACC_WIDTH = 10,
   parameter int OUT_WIDTH = 8
) (
   input  logic [ACC_WIDTH-1:0] acc,
   output logic [OUT_WIDTH-1:0] res,
   output logic                 sat
);

`ifdef CASE_4_ACC_SATURATE_EN
   localparam logic signed [ACC_WIDTH-1:0] MAX_V =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] MIN_V = ~MAX_V;

   // Clamp to the signed OUT_WIDTH range and flag when clamping happened.
   always_comb begin
      res = acc[OUT_WIDTH-1:0];
      sat = 1'b0;
      if ($signed(acc) > MAX_V) begin
         res = MAX_V[OUT_WIDTH-1:0];
         sat = 1'b1;
      end else if ($signed(acc) < MIN_V) begin
         res = MIN_V[OUT_WIDTH-1:0];
         sat = 1'b1;
      end
   end
`else
   // Upper sum bits are dropped by design, same as the multiplier upstream.
   logic unused_hi;
   assign unused_hi = ^acc[ACC_WIDTH-1:OUT_WIDTH];
   assign res       = acc[OUT_WIDTH-1:0];
   assign sat       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/case_4_prod_accum.sv
`default_nettype none
// ============================================================================
//  Module      : case_4_prod_accum
//  Description : Sums each group of COUNT signed products arriving on a
//                valid/ready stream and emits one registered signed result
//                per group. Zero-bubble hand-over between groups.
//                Optional clamping: define CASE_4_ACC_SATURATE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module case_4_prod_accum
   import case_4_acc_pkg::*;
#(
   parameter int IN_WIDTH  = DEF_IN_WIDTH,
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int OUT_WIDTH = DEF_OUT_WIDTH,
   parameter int COUNT     = DEF_COUNT,
   parameter int CNT_WIDTH = $clog2(COUNT) + 1
) (
   input  logic               ap_clk,
   input  logic               ap_rst_n,
   case_4_prod_accum_if.slave bus
);

   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(COUNT - 1);
   localparam logic [CNT_WIDTH-1:0] ONE_CNT  = CNT_WIDTH'(1);
   localparam bit                   SINGLE   = (COUNT == 1);

   state_t                state, state_nxt;
   logic [ACC_WIDTH-1:0]  acc, acc_nxt, acc_base, acc_sum;
   logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
   logic [OUT_WIDTH-1:0]  out_data_q, out_data_nxt, res;
   logic                  out_valid_q, out_valid_nxt;
   logic                  out_sat_q, out_sat_nxt, res_sat;
   logic                  accept_in, accept_out;

   // In HOLD the slot frees only when the result leaves, so input is gated by out_ready.
   assign bus.in_ready = (state == HOLD) ? bus.out_ready : 1'b1;
   assign accept_in    = bus.in_valid & bus.in_ready;
   assign accept_out   = out_valid_q & bus.out_ready;

   // A single adder serves both cases: outside ACCUM the beat starts a new group.
   assign acc_base = (state == ACCUM) ? acc : '0;
   assign acc_sum  = acc_base + ACC_WIDTH'(sext_in(32'(bus.in_data), IN_WIDTH));

   case_4_acc_sat #(
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_sat (
      .acc (acc_sum),
      .res (res),
      .sat (res_sat)
   );

   // Next-state, accumulator, counter and result-register update.
   always_comb begin
      state_nxt     = state;
      acc_nxt       = acc;
      cnt_nxt       = cnt;
      out_data_nxt  = out_data_q;
      out_valid_nxt = out_valid_q;
      out_sat_nxt   = out_sat_q;
      case (state)
         IDLE, HOLD: begin
            if (state == HOLD && accept_out) begin
               out_valid_nxt = 1'b0;
               acc_nxt       = '0;
               cnt_nxt       = '0;
               state_nxt     = IDLE;
            end
            // In HOLD an accepted beat implies the result was also taken.
            if (accept_in) begin
               acc_nxt = acc_sum;
               cnt_nxt = ONE_CNT;
               if (SINGLE) begin
                  out_data_nxt  = res;
                  out_sat_nxt   = res_sat;
                  out_valid_nxt = 1'b1;
                  state_nxt     = HOLD;
               end else begin
                  state_nxt = ACCUM;
               end
            end
         end
         ACCUM: begin
            if (accept_in) begin
               acc_nxt = acc_sum;
               cnt_nxt = cnt + ONE_CNT;
               if (cnt == LAST_CNT) begin
                  out_data_nxt  = res;
                  out_sat_nxt   = res_sat;
                  out_valid_nxt = 1'b1;
                  state_nxt     = HOLD;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and datapath registers; async reset discards any partial group.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state       <= IDLE;
         acc         <= '0;
         cnt         <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_sat_q   <= 1'b0;
      end else begin
         state       <= state_nxt;
         acc         <= acc_nxt;
         cnt         <= cnt_nxt;
         out_data_q  <= out_data_nxt;
         out_valid_q <= out_valid_nxt;
         out_sat_q   <= out_sat_nxt;
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sat   = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_case_4_prod_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_case_4_prod_accum
//  Description : Scoreboard bench for case_4_prod_accum (defaults:
//                IN=8, ACC=10, OUT=8, COUNT=4). Expected results follow
//                CASE_4_ACC_SATURATE_EN when it is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_case_4_prod_accum;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   bit   rand_ready;
   logic [8:0] exp_q[$];   // {sat, data}

   case_4_prod_accum_if #(.IN_WIDTH(8), .OUT_WIDTH(8)) bus ();

   case_4_prod_accum dut (
      .ap_clk   (clk),
      .ap_rst_n (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   // Group result reference: plain integer sum, then truncate or clamp.
   function automatic logic [8:0] expect_of(input int s);
`ifdef CASE_4_ACC_SATURATE_EN
      if (s > 127)  return {1'b1, 8'h7F};
      if (s < -128) return {1'b1, 8'h80};
`endif
      return {1'b0, 8'(s)};
   endfunction

   // Present one beat, wait (bounded) for in_ready, hand it over at the next edge.
   task automatic send_beat(input logic [7:0] d);
      int w;
      w = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(negedge clk);
      while (!bus.in_ready && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: got in_ready 0 after %0d cycles, expected 1", w);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("drain_pending", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] d;
      int         s;
      checks         = 0;
      errors         = 0;
      rand_ready     = 1'b0;
      rst_n          = 1'b1;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.out_ready  = 1'b1;

      fork
         // Monitor: every accepted output is compared against the scoreboard head.
         forever begin
            logic [8:0] e;
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: got data %0d, expected no output", bus.out_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_data", int'(bus.out_data), int'(e[7:0]));
                  chk("out_sat", int'(bus.out_sat), int'(e[8]));
               end
            end
         end
         // Optional random back-pressure.
         forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
         end
         begin
            #2000000;
            $display("FAIL watchdog: got no end of test, expected finish");
            $fatal(1, "watchdog expired");
         end
      join_none

      // Reset state
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", int'(bus.out_valid), 0);
      chk("reset_out_data",  int'(bus.out_data),  0);
      chk("reset_out_sat",   int'(bus.out_sat),   0);
      chk("reset_in_ready",  int'(bus.in_ready),  1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // T1: 10, -3, 7, 1 -> 15; valid one cycle after last beat, for one cycle
      send_beat(8'h0A); send_beat(8'hFD); send_beat(8'h07); send_beat(8'h01);
      exp_q.push_back({1'b0, 8'd15});
      @(negedge clk);
      chk("t1_valid_after_last", int'(bus.out_valid), 1);
      @(negedge clk);
      chk("t1_valid_one_cycle", int'(bus.out_valid), 0);
      @(posedge clk);
      #1;

      // T2: 127 x4 = 508 ; T3: -128 x4 = -512 (T3 starts while T2 is in HOLD)
      send_beat(8'h7F); send_beat(8'h7F); send_beat(8'h7F); send_beat(8'h7F);
`ifdef CASE_4_ACC_SATURATE_EN
      exp_q.push_back({1'b1, 8'h7F});
`else
      exp_q.push_back({1'b0, 8'hFC});
`endif
      send_beat(8'h80); send_beat(8'h80); send_beat(8'h80); send_beat(8'h80);
`ifdef CASE_4_ACC_SATURATE_EN
      exp_q.push_back({1'b1, 8'h80});
`else
      exp_q.push_back({1'b0, 8'h00});
`endif
      wait_drain();

      // T4: back-pressure in HOLD with the next beat already waiting
      bus.out_ready = 1'b0;
      send_beat(8'h01); send_beat(8'h02); send_beat(8'h03); send_beat(8'h04);
      exp_q.push_back({1'b0, 8'd10});
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h02;
      repeat (5) begin
         @(negedge clk);
         chk("t4_in_ready_low",   int'(bus.in_ready),  0);
         chk("t4_out_valid_held", int'(bus.out_valid), 1);
         chk("t4_out_data_held",  int'(bus.out_data),  10);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send_beat(8'h02); send_beat(8'h03); send_beat(8'h04); send_beat(8'h05);
      exp_q.push_back({1'b0, 8'd14});
      wait_drain();

      // T5: random data, bubbles and back-pressure
      rand_ready = 1'b1;
      for (int g = 0; g < 200; g++) begin
         s = 0;
         for (int b = 0; b < 4; b++) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
            d = 8'($urandom_range(0, 255));
            send_beat(d);
            s = s + int'($signed(d));
         end
         exp_q.push_back(expect_of(s));
      end
      rand_ready    = 1'b0;
      bus.out_ready = 1'b1;
      wait_drain();

      // T6a: reset while a result is held clears the outputs asynchronously
      bus.out_ready = 1'b0;
      send_beat(8'h03); send_beat(8'h03); send_beat(8'h03); send_beat(8'h03);
      @(negedge clk);
      chk("t6_held_valid", int'(bus.out_valid), 1);
      chk("t6_held_data",  int'(bus.out_data),  12);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_out_valid", int'(bus.out_valid), 0);
      chk("t6_rst_out_data",  int'(bus.out_data),  0);
      chk("t6_rst_in_ready",  int'(bus.in_ready),  1);
      @(negedge clk);
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;

      // T6b: reset after a partial group 5,5; next group 1,1,1,1 -> 4
      send_beat(8'h05); send_beat(8'h05);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_partial_out_valid", int'(bus.out_valid), 0);
      chk("t6_partial_out_data",  int'(bus.out_data),  0);
      chk("t6_partial_out_sat",   int'(bus.out_sat),   0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_beat(8'h01); send_beat(8'h01); send_beat(8'h01); send_beat(8'h01);
      exp_q.push_back({1'b0, 8'd4});
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
